// File: rtl/clb_param_if.sv
// clb_param_if: signal bundle for one configurable logic block.
//   Logic side  : IN (logic inputs), CE, SR, OUT (cell outputs)
//   Config side : CFG_DIN, CFG_EN, CFG_COMMIT, CFG_DOUT, CFG_DONE, CFG_ERR
//                 and CFG_READ when CLB_READBACK_EN is defined.
//   master modport drives the inputs of the block, slave modport is the block.
interface clb_param_if #(
    parameter int N_IN    = 4,
    parameter int N_CELLS = 2
);
    logic [N_IN-1:0]    IN;
    logic               CE;
    logic               SR;
    logic               CFG_DIN;
    logic               CFG_EN;
    logic               CFG_COMMIT;
`ifdef CLB_READBACK_EN
    logic               CFG_READ;
`endif
    logic               CFG_DOUT;
    logic               CFG_DONE;
    logic               CFG_ERR;
    logic [N_CELLS-1:0] OUT;

    modport master (
`ifdef CLB_READBACK_EN
        output CFG_READ,
`endif
        output IN, CE, SR, CFG_DIN, CFG_EN, CFG_COMMIT,
        input  CFG_DOUT, CFG_DONE, CFG_ERR, OUT
    );

    modport slave (
`ifdef CLB_READBACK_EN
        input  CFG_READ,
`endif
        input  IN, CE, SR, CFG_DIN, CFG_EN, CFG_COMMIT,
        output CFG_DOUT, CFG_DONE, CFG_ERR, OUT
    );
endinterface

// File: rtl/clb_param.sv
// clb_param: parametrised configurable logic block (fabric tile).
//   N_CELLS cells, each a LUT_K-input LUT whose inputs are picked by a per-input
//   source select (IN bits or registered cell outputs), with an optional output
//   register carrying a synchronous set/reset value.
//   Configuration is shifted serially into a shadow frame and copied to the
//   active frame by an atomic commit; CFG_DOUT = shadow bit 0 for daisy-chaining.
// Ports:
//   K      - clock, rising edge
//   RST_N  - asynchronous active-low reset
//   bus    - clb_param_if.slave (logic inputs/outputs and config chain)
// Optional feature: define CLB_READBACK_EN to add CFG_READ, which copies the
//   active frame into the shadow so it can be streamed out on CFG_DOUT.
// Cell field layout (LSB first, at offset c*CW):
//   LUT[2**LUT_K], SEL0..SEL(LUT_K-1)[SEL_W], OUT_REG, SR_EN, SRVAL
module clb_param #(
    parameter int LUT_K   = 4,
    parameter int N_IN    = 4,
    parameter int N_CELLS = 2
) (
    input logic        K,
    input logic        RST_N,
    clb_param_if.slave bus
);
    localparam int SEL_W    = $clog2(N_IN + N_CELLS);
    localparam int LUT_W    = 2 ** LUT_K;
    localparam int CW       = LUT_W + LUT_K * SEL_W + 3;
    localparam int FRAME_W  = N_CELLS * CW;
    localparam int CNT_W    = $clog2(FRAME_W + 2);
    localparam int SRC_W    = 2 ** SEL_W;
    localparam int OREG_OFS = LUT_W + LUT_K * SEL_W;

    typedef enum logic [1:0] {
        ST_UNCFG  = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_RELOAD = 2'd3
    } state_t;

    state_t                           state_q, state_d;
    logic [FRAME_W-1:0]               shadow_q, shadow_d;
    logic [FRAME_W-1:0]               active_q, active_d;
    logic [N_CELLS-1:0]               q_q, q_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             err_q, err_d;

    logic                             done_s;
    logic                             loading_s;
    logic                             good_commit_s;
    logic                             bad_commit_s;
    logic                             read_s;
    logic [SRC_W-1:0]                 src_s;
    logic [N_CELLS-1:0][LUT_K-1:0]    idx_s;
    logic [N_CELLS-1:0][LUT_W-1:0]    lut_s;
    logic [N_CELLS-1:0]               f_s;
    logic [N_CELLS-1:0]               out_s;

    // A commit is only good with a complete frame and no shift in the same cycle.
    assign good_commit_s = bus.CFG_COMMIT & ~bus.CFG_EN & loading_s
                         & (cnt_q == CNT_W'(FRAME_W));
    assign bad_commit_s  = bus.CFG_COMMIT & ~good_commit_s;

`ifdef CLB_READBACK_EN
    assign read_s = bus.CFG_READ & ~bus.CFG_EN & done_s;
`else
    assign read_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge K or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_UNCFG;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: commit outcome takes priority over starting a load.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNCFG: begin
                if (bad_commit_s)     state_d = ST_UNCFG;
                else if (bus.CFG_EN)  state_d = ST_LOAD;
                else                  state_d = ST_UNCFG;
            end
            ST_LOAD: begin
                if (good_commit_s)     state_d = ST_RUN;
                else if (bad_commit_s) state_d = ST_UNCFG;
                else                   state_d = ST_LOAD;
            end
            ST_RUN: begin
                if (bad_commit_s)     state_d = ST_RUN;
                else if (bus.CFG_EN)  state_d = ST_RELOAD;
                else                  state_d = ST_RUN;
            end
            ST_RELOAD: begin
                if (good_commit_s || bad_commit_s) state_d = ST_RUN;
                else                               state_d = ST_RELOAD;
            end
            default: state_d = ST_UNCFG;
        endcase
    end

    // State decode outputs.
    always_comb begin
        done_s    = (state_q == ST_RUN) || (state_q == ST_RELOAD);
        loading_s = (state_q == ST_LOAD) || (state_q == ST_RELOAD);
    end

    // Source vector seen by every SEL: IN bits, then cell Q feedback, rest zero.
    always_comb begin
        src_s                  = '0;
        src_s[N_IN-1:0]        = bus.IN;
        src_s[N_IN +: N_CELLS] = q_q;
    end

    // LUT evaluation and output mux for each cell (active frame only).
    always_comb begin
        idx_s = '0;
        lut_s = '0;
        f_s   = '0;
        out_s = '0;
        for (int c = 0; c < N_CELLS; c++) begin
            lut_s[c] = active_q[c*CW +: LUT_W];
            for (int i = 0; i < LUT_K; i++) begin
                idx_s[c][i] = src_s[active_q[c*CW + LUT_W + i*SEL_W +: SEL_W]];
            end
            f_s[c] = lut_s[c][idx_s[c]];
            if (active_q[c*CW + OREG_OFS]) out_s[c] = q_q[c];
            else                           out_s[c] = f_s[c];
        end
    end

    // Config chain, commit handling and cell register next values.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        q_d      = q_q;

        if (bus.CFG_EN) begin
            shadow_d = {bus.CFG_DIN, shadow_q[FRAME_W-1:1]};
            // Saturate one past a full frame so an over-long load is still rejected.
            if (cnt_q != CNT_W'(FRAME_W + 1)) cnt_d = cnt_q + CNT_W'(1);
            else                              cnt_d = cnt_q;
        end else if (read_s) begin
            shadow_d = active_q;
            cnt_d    = '0;
        end else begin
            shadow_d = shadow_q;
        end

        if (good_commit_s) begin
            active_d = shadow_q;
            cnt_d    = '0;
            err_d    = 1'b0;
        end else if (bad_commit_s) begin
            cnt_d    = '0;
            err_d    = 1'b1;
        end else begin
            active_d = active_q;
        end

        for (int c = 0; c < N_CELLS; c++) begin
            if (good_commit_s)
                q_d[c] = shadow_q[c*CW + OREG_OFS + 2];
            else if (done_s && active_q[c*CW + OREG_OFS + 1] && bus.SR)
                q_d[c] = active_q[c*CW + OREG_OFS + 2];
            else if (done_s && bus.CE)
                q_d[c] = f_s[c];
            else
                q_d[c] = q_q[c];
        end
    end

    // Datapath registers.
    always_ff @(posedge K or negedge RST_N) begin
        if (!RST_N) begin
            shadow_q <= '0;
            active_q <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.CFG_DOUT = shadow_q[0];
    assign bus.CFG_DONE = done_s;
    assign bus.CFG_ERR  = err_q;
    assign bus.OUT      = out_s;
endmodule
